ctrl_pipe: RTL and testbench

Parametrised control-signal pipeline that carries decoded control words from the decode stage through a configurable number of downstream pipeline registers. Each stage has its own stall and flush, and holds propagate toward the decode stage. A valid bit travels with every stage, and bubbles are inserted automatically when an upstream stage holds while a downstream stage advances. It sits between the decoders and the datapath in the pipelined core and generalises the fixed three-register ID/EX, EX/MEM, MEM/WB control chain. It adds valid tracking, per-stage stall and a bubble counter for the hazard unit.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/ctrl_pipe_stage.sv | 30 +++
 rtl/ctrl_pipe.sv | 78 +++++++
 tb/tb_ctrl_pipe.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the decoded control-word pipeline: field layout of the
// existing stage boundaries and the default bubble-counter width.
package pipe_ctrl_pkg;

    // Nested layout: WB fields sit at the bottom, MEM above them, EX on top,
    // so each later boundary is a low slice of the earlier one.
    localparam int WB_OFF   = 0;
    localparam int WB_W     = 2;
    localparam int MEM_OFF  = WB_OFF + WB_W;
    localparam int MEM_W    = 7;
    localparam int EX_OFF   = MEM_OFF + MEM_W;
    localparam int EX_W     = 16;

    localparam int ID_EX_W  = EX_W + MEM_W + WB_W;
    localparam int EX_MEM_W = MEM_W + WB_W;
    localparam int MEM_WB_W = WB_W;

    localparam int CNT_W_DEF = 16;

    function automatic logic [CNT_W_DEF-1:0] sat_inc16(input logic [CNT_W_DEF-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/ctrl_pipe_stage.sv
// One control-pipeline register: control word plus its valid bit, with clear,
// hold (enable low) and bubble insertion.
module ctrl_pipe_stage #(
    parameter int WIDTH = 25
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_bubble,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_v,
    output logic [WIDTH-1:0] o_q,
    output logic             o_v
);

    logic [WIDTH:0] r_stage;

    always_ff @(posedge clk) begin
        if (reset || i_clr) begin
            r_stage <= '0;
        end else if (i_en) begin
            r_stage <= i_bubble ? '0 : {i_v, i_d};
        end
    end

    assign o_q = r_stage[WIDTH-1:0];
    assign o_v = r_stage[WIDTH];

endmodule

// File: rtl/ctrl_pipe.sv
// Decoded control-word pipeline with per-stage stall/flush, valid tracking,
// automatic bubble insertion and a saturating bubble counter.
module ctrl_pipe
    import pipe_ctrl_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int WIDTH  = ID_EX_W,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          i_d,
    input  logic                      i_valid,
    input  logic [STAGES-1:0]         i_stall,
    input  logic [STAGES-1:0]         i_flush,
    output logic [STAGES*WIDTH-1:0]   o_q,
    output logic [STAGES-1:0]         o_valid,
    output logic                      o_stall_up,
    output logic [CNT_W-1:0]          o_bubble_cnt
);

    logic [STAGES-1:0] w_hold;
    logic [STAGES-1:0] w_bub;
    logic [WIDTH-1:0]  w_q [STAGES];
    logic [STAGES-1:0] w_v;
    logic [CNT_W-1:0]  r_cnt;

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            // A stage holds if it or any stage downstream of it stalls.
            assign w_hold[k] = |(i_stall >> k);

            if (k == 0) begin : g_head
                assign w_bub[k] = 1'b0;
                ctrl_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                    .clk      (clk),
                    .reset    (reset),
                    .i_clr    (i_flush[k]),
                    .i_en     (~w_hold[k]),
                    .i_bubble (~i_valid),
                    .i_d      (i_d),
                    .i_v      (i_valid),
                    .o_q      (w_q[k]),
                    .o_v      (w_v[k])
                );
            end else begin : g_body
                assign w_bub[k] = ~i_flush[k] & ~w_hold[k] & w_hold[k-1];
                ctrl_pipe_stage #(.WIDTH(WIDTH)) u_stage (
                    .clk      (clk),
                    .reset    (reset),
                    .i_clr    (i_flush[k]),
                    .i_en     (~w_hold[k]),
                    .i_bubble (w_hold[k-1]),
                    .i_d      (w_q[k-1]),
                    .i_v      (w_v[k-1]),
                    .o_q      (w_q[k]),
                    .o_v      (w_v[k])
                );
            end

            assign o_q[k*WIDTH +: WIDTH] = w_q[k];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if ((|w_bub) && !(&r_cnt)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_valid      = w_v;
    assign o_stall_up   = w_hold[0];
    assign o_bubble_cnt = r_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed bench for ctrl_pipe with STAGES=3, WIDTH=8, CNT_W=16.
module tb_ctrl_pipe;

    localparam int S = 3;
    localparam int W = 8;
    localparam int C = 16;

    logic           clk;
    logic           reset;
    logic [W-1:0]   i_d;
    logic           i_valid;
    logic [S-1:0]   i_stall;
    logic [S-1:0]   i_flush;
    logic [S*W-1:0] o_q;
    logic [S-1:0]   o_valid;
    logic           o_stall_up;
    logic [C-1:0]   o_bubble_cnt;

    int n_chk = 0;
    int n_err = 0;

    ctrl_pipe #(.STAGES(S), .WIDTH(W), .CNT_W(C)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_d          (i_d),
        .i_valid      (i_valid),
        .i_stall      (i_stall),
        .i_flush      (i_flush),
        .o_q          (o_q),
        .o_valid      (o_valid),
        .o_stall_up   (o_stall_up),
        .o_bubble_cnt (o_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d, input logic v);
        i_d = d;
        i_valid = v;
        step();
    endtask

    initial begin
        reset = 1'b1; i_d = '0; i_valid = 1'b0; i_stall = '0; i_flush = '0;
        step();
        step();
        check("rst_q", o_q, 0);
        check("rst_v", o_valid, 0);
        check("rst_cnt", o_bubble_cnt, 0);
        i_stall = 3'b100;
        #1;
        check("rst_stall_up", o_stall_up, 1);
        i_stall = '0;
        #1;
        check("rst_stall_up0", o_stall_up, 0);
        reset = 1'b0;

        // Free flow
        push(8'h11, 1'b1);
        check("ff_s0", o_q[7:0], 8'h11);
        push(8'h22, 1'b1);
        push(8'h33, 1'b1);
        check("ff_c3", o_q[23:16], 8'h11);
        check("ff_c3_v", o_valid, 3'b111);
        push(8'h00, 1'b0);
        check("ff_c4", o_q[23:16], 8'h22);
        check("ff_c4_v2", o_valid[2], 1);
        push(8'h00, 1'b0);
        check("ff_c5", o_q[23:16], 8'h33);
        check("ff_c5_v2", o_valid[2], 1);
        check("ff_cnt", o_bubble_cnt, 0);

        // Stall on stage 1 for two cycles
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        push(8'h33, 1'b1);
        check("st_pre", o_q, 24'h112233);
        i_d = 8'h55; i_valid = 1'b1; i_stall = 3'b010;
        #1;
        check("st_up", o_stall_up, 1);
        for (int c = 1; c <= 2; c++) begin
            step();
            check("st_q", o_q, 24'h002233);
            check("st_v", o_valid, 3'b011);
            check("st_cnt", o_bubble_cnt, c);
        end
        i_stall = '0;
        push(8'h44, 1'b1);
        check("st_rel", o_q, 24'h223344);
        check("st_rel_v", o_valid, 3'b111);

        // Flush and stall together on stage 1
        i_flush = 3'b010; i_stall = 3'b010; i_d = 8'h66;
        #1;
        check("fs_up", o_stall_up, 1);
        step();
        check("fs_q", o_q, 24'h000044);
        check("fs_v", o_valid, 3'b001);
        check("fs_cnt", o_bubble_cnt, 3);
        i_flush = '0; i_stall = '0;

        // Invalid input produces an all-zero word
        push(8'hFF, 1'b0);
        check("inv_s0", o_q[7:0], 8'h00);
        check("inv_v0", o_valid[0], 0);

        // Reset mid-stream overrides stall and flush
        push(8'h11, 1'b1);
        push(8'h22, 1'b1);
        push(8'h33, 1'b1);
        check("mid_pre_v", o_valid, 3'b111);
        reset = 1'b1; i_stall = 3'b111; i_flush = 3'b010;
        step();
        check("mid_q", o_q, 0);
        check("mid_v", o_valid, 0);
        check("mid_cnt", o_bubble_cnt, 0);
        reset = 1'b0; i_stall = '0; i_flush = '0; i_valid = 1'b0; i_d = '0;

        // Saturation: stage 1 takes a bubble every cycle
        i_stall = 3'b001;
        for (int c = 0; c < 65534; c++) step();
        check("sat_fffe", o_bubble_cnt, 16'hFFFE);
        step();
        check("sat_ffff", o_bubble_cnt, 16'hFFFF);
        for (int c = 0; c < 5; c++) step();
        check("sat_hold", o_bubble_cnt, 16'hFFFF);
        check("sat_up", o_stall_up, 1);
        reset = 1'b1;
        step();
        check("sat_rst", o_bubble_cnt, 0);
        reset = 1'b0; i_stall = '0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
